// File: rtl/pipe_pkg.sv
// Shared types and default widths for the inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       spare;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam int CTRL_W_DEF   = $bits(ctrl_t);
  localparam int DATA_W_IF_ID = 64;
  localparam int DATA_W_ID_EX = 181;
  localparam int DATA_W_EX_MEM = 106;
  localparam int DATA_W_MEM_WB = 69;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle carrying control and data between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 181
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid flag plus control and data payload.
module pipe_entry_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 181
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // clear zeroes control so a flushed slot is a NOP bubble; data is kept as-is
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end else if (drop) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid, stall, flush and stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 9,
  parameter int DATA_W  = 181,
  parameter int CNT_W   = 16,
  parameter int SKID_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  pipe_stage_skid_if.slave    in_bus,
  pipe_stage_skid_if.master   out_bus,
  output logic [CNT_W-1:0]    stall_cycles
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic              accept, emit;
  logic              main_load, main_from_skid, main_drop;
  logic              skid_load, skid_drop;
  occ_e              occ;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_bus.ready = !skid_v && !stall;
    end else begin : g_single
      assign in_bus.ready = (!main_v || out_bus.ready) && !stall;
    end
  endgenerate

  assign out_bus.valid = main_v && !stall;
  assign out_bus.ctrl  = main_ctrl;
  assign out_bus.data  = main_data;

  assign accept = in_bus.valid && in_bus.ready;
  assign emit   = out_bus.valid && out_bus.ready;

  always_comb begin
    occ = EMPTY;
    if (skid_v)      occ = FULL;
    else if (main_v) occ = ONE;
  end

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (occ)
      EMPTY: main_load = accept;
      ONE: begin
        if (accept && emit)                      main_load = 1'b1;
        else if (accept && (SKID_EN != 0))       skid_load = 1'b1;
        else if (emit)                           main_drop = 1'b1;
      end
      FULL: begin
        if (emit) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_bus.ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_bus.data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (flush),
    .drop    (main_drop),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (main_v),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (flush),
    .drop    (skid_drop),
    .d_ctrl  (in_bus.ctrl),
    .d_data  (in_bus.data),
    .q_valid (skid_v),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

  always_ff @(posedge clk) begin
    if (rst)                              stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, stall, flush, saturation.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 181;

  logic clk = 1'b0;
  logic rst, stall, flush, stall2;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles2;
  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) in_bus ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) out_bus ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) in_bus2 ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) out_bus2 ();

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16), .SKID_EN(1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .in_bus       (in_bus),
    .out_bus      (out_bus),
    .stall_cycles (stall_cycles)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4), .SKID_EN(1)) u_dut_sat (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall2),
    .flush        (1'b0),
    .in_bus       (in_bus2),
    .out_bus      (out_bus2),
    .stall_cycles (stall_cycles2)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input int d);
    in_bus.valid = v;
    in_bus.ctrl  = c;
    in_bus.data  = DATA_W'(d);
  endtask

  // leaves the stage FULL holding d1 (main) and d2 (skid)
  task automatic fill_full(input logic [8:0] c, input int d1, input int d2);
    out_bus.ready = 1'b0;
    drive(1'b1, c, d1);
    tick();
    drive(1'b1, c, d2);
    tick();
    drive(1'b0, 9'h0, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; stall2 = 1'b0;
    in_bus.valid = 1'b1; in_bus.ctrl = '1; in_bus.data = '1;
    out_bus.ready = 1'b1;
    in_bus2.valid = 1'b0; in_bus2.ctrl = '0; in_bus2.data = '0;
    out_bus2.ready = 1'b1;

    // reset with all-ones on the inputs
    tick(); tick();
    chk("rst_out_valid", 192'(out_bus.valid), 192'(0));
    chk("rst_out_ctrl", 192'(out_bus.ctrl), 192'(0));
    chk("rst_out_data", 192'(out_bus.data), 192'(0));
    chk("rst_stall_cycles", 192'(stall_cycles), 192'(0));
    rst = 1'b0;
    drive(1'b0, 9'h0, 0);
    #1;
    chk("rst_in_ready", 192'(in_bus.ready), 192'(1));

    // streaming 1..8 with 1-cycle latency
    out_bus.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 9'(i), i);
      #1;
      chk("stream_in_ready", 192'(in_bus.ready), 192'(1));
      tick();
      chk("stream_out_valid", 192'(out_bus.valid), 192'(1));
      chk("stream_out_data", 192'(out_bus.data), 192'(i));
      chk("stream_out_ctrl", 192'(out_bus.ctrl), 192'(i));
    end
    drive(1'b0, 9'h0, 0);
    tick();
    chk("stream_drain_valid", 192'(out_bus.valid), 192'(0));

    // backpressure: 2 lands in skid, 3 is refused
    out_bus.ready = 1'b0;
    drive(1'b1, 9'h0A0, 1);
    tick();
    drive(1'b1, 9'h0A0, 2);
    #1;
    chk("bp_ready_one", 192'(in_bus.ready), 192'(1));
    tick();
    chk("bp_ready_full", 192'(in_bus.ready), 192'(0));
    chk("bp_hold_data1", 192'(out_bus.data), 192'(1));
    drive(1'b1, 9'h0A0, 3);
    tick();
    chk("bp_still_data1", 192'(out_bus.data), 192'(1));
    chk("bp_still_full", 192'(in_bus.ready), 192'(0));
    drive(1'b0, 9'h0, 0);
    out_bus.ready = 1'b1;
    #1;
    chk("bp_emit1_valid", 192'(out_bus.valid), 192'(1));
    chk("bp_emit1_data", 192'(out_bus.data), 192'(1));
    tick();
    chk("bp_emit2_data", 192'(out_bus.data), 192'(2));
    chk("bp_emit2_valid", 192'(out_bus.valid), 192'(1));
    chk("bp_emit2_ready", 192'(in_bus.ready), 192'(1));
    tick();
    chk("bp_empty", 192'(out_bus.valid), 192'(0));

    // stall for 5 cycles while FULL
    fill_full(9'h055, 1, 2);
    stall = 1'b1;
    out_bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_out_valid", 192'(out_bus.valid), 192'(0));
      chk("stall_in_ready", 192'(in_bus.ready), 192'(0));
      tick();
    end
    stall = 1'b0;
    #1;
    chk("stall_count5", 192'(stall_cycles), 192'(5));
    chk("stall_drain1", 192'(out_bus.data), 192'(1));
    chk("stall_drain1_v", 192'(out_bus.valid), 192'(1));
    tick();
    chk("stall_drain2", 192'(out_bus.data), 192'(2));
    tick();
    chk("stall_drained", 192'(out_bus.valid), 192'(0));

    // flush while FULL with a concurrent offer of 3
    fill_full(9'h1FF, 1, 2);
    flush = 1'b1;
    drive(1'b1, 9'h1FF, 3);
    tick();
    flush = 1'b0;
    drive(1'b0, 9'h0, 0);
    #1;
    chk("flush_full_valid", 192'(out_bus.valid), 192'(0));
    chk("flush_full_ctrl", 192'(out_bus.ctrl), 192'(0));
    chk("flush_full_ready", 192'(in_bus.ready), 192'(1));
    out_bus.ready = 1'b1;
    tick();
    chk("flush_full_no3", 192'(out_bus.valid), 192'(0));

    // flush while ONE: the accepted 3 must be discarded
    out_bus.ready = 1'b0;
    drive(1'b1, 9'h1FF, 4);
    tick();
    flush = 1'b1;
    drive(1'b1, 9'h1FF, 3);
    #1;
    chk("flush_one_ready", 192'(in_bus.ready), 192'(1));
    tick();
    flush = 1'b0;
    drive(1'b0, 9'h0, 0);
    out_bus.ready = 1'b1;
    #1;
    chk("flush_one_valid", 192'(out_bus.valid), 192'(0));
    chk("flush_one_ctrl", 192'(out_bus.ctrl), 192'(0));
    tick();
    chk("flush_one_no3", 192'(out_bus.valid), 192'(0));

    // flush wins over stall
    fill_full(9'h1FF, 6, 7);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    out_bus.ready = 1'b1;
    #1;
    chk("sf_out_valid", 192'(out_bus.valid), 192'(0));
    chk("sf_in_ready", 192'(in_bus.ready), 192'(1));
    chk("sf_out_ctrl", 192'(out_bus.ctrl), 192'(0));

    // reset wins over flush: data zeroed too, counter cleared
    drive(1'b1, 9'h1FF, 5);
    tick();
    chk("rf_pre_data", 192'(out_bus.data), 192'(5));
    drive(1'b0, 9'h0, 0);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("rf_out_valid", 192'(out_bus.valid), 192'(0));
    chk("rf_out_ctrl", 192'(out_bus.ctrl), 192'(0));
    chk("rf_out_data", 192'(out_bus.data), 192'(0));
    chk("rf_stall_cycles", 192'(stall_cycles), 192'(0));
    chk("rf_in_ready", 192'(in_bus.ready), 192'(1));

    // 4-bit counter saturates at 15
    stall2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_count14", 192'(stall_cycles2), 192'(14));
    end
    stall2 = 1'b0;
    tick();
    chk("sat_count15", 192'(stall_cycles2), 192'(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
